// File: rtl/freq_meter_pkg.sv
// Shared encodings and constants for the gated frequency meter.
// The FSM state type is visible to anything that imports this package.
package freq_meter_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;

    // Cycles spent discarding stale synchronizer contents before a window opens.
    localparam int FLUSH_CYCLES = 3;
    localparam int FLUSH_W      = $clog2(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

endpackage

// File: rtl/edge_sync_rise.sv
// Two-flop synchronizer plus a third flop for rising-edge detection.
// An input edge shows up on rise three clk cycles later, for one cycle.
module edge_sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/freq_meter_1hz_gate.sv
// Counts rising edges of an asynchronous input over a fixed gate window and
// publishes the count (Hz for a 1 s gate) once per completed window.
module freq_meter_1hz_gate
    import freq_meter_pkg::*;
#(
    parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
    parameter int GATE_CYCLES = CLK_FREQ,
    parameter int CNT_WIDTH   = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] freq_out,
    output logic                 freq_valid,
    output logic                 overflow
);

    localparam int                   GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_t               state;
    state_t               state_nxt;
    logic [FLUSH_W-1:0]   flush_cnt;
    logic [GATE_W-1:0]    gate_cnt;
    logic [CNT_WIDTH-1:0] edge_cnt;
    logic [CNT_WIDTH-1:0] edge_next;
    logic                 sat;
    logic                 sat_hit;
    logic                 cnt_at_max;
    logic                 rise;
    logic                 flush_done;
    logic                 count_en;
    logic                 publish;

    edge_sync_rise u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sig_in),
        .rise  (rise)
    );

    assign flush_done = (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1));

    // Saturating increment; sat_hit marks an edge lost at all-ones.
    assign cnt_at_max = (edge_cnt == CNT_MAX);
    assign sat_hit    = rise & cnt_at_max;
    assign edge_next  = (rise && !cnt_at_max) ? edge_cnt + CNT_WIDTH'(1) : edge_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_en  = 1'b0;
        publish   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!en)             state_nxt = ST_IDLE;
                else if (flush_done) state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else begin
                    count_en = 1'b1;
                    publish  = (gate_cnt == GATE_LAST);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // freq_valid is a one-cycle strobe with no ready: the consumer samples
    // freq_out/overflow in that cycle; both then hold until the next strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt  <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;

            if (state == ST_FLUSH && en && !flush_done) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end else begin
                flush_cnt <= '0;
            end

            if (!count_en) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (publish) begin
                // A rise on the terminal cycle still belongs to the closing window.
                freq_out   <= edge_next;
                overflow   <= sat | sat_hit;
                freq_valid <= 1'b1;
                gate_cnt   <= '0;
                edge_cnt   <= '0;
                sat        <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                edge_cnt <= edge_next;
                sat      <= sat | sat_hit;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_1hz_gate.sv
// Bench for freq_meter_1hz_gate: two instances (27-bit and 4-bit counters)
// share stimulus; window counts are derived from the recorded sig_in history.
module tb_freq_meter_1hz_gate;
    import freq_meter_pkg::*;

    localparam int GATE       = 100;
    localparam int FIRST_TERM = FLUSH_CYCLES + GATE;
    localparam int HIST       = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        sig_in = 1'b0;
    logic [26:0] freq_out;
    logic        freq_valid;
    logic        overflow;
    logic [3:0]  freq_out4;
    logic        freq_valid4;
    logic        overflow4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;
    int sig_period = 0;
    int ph = 0;
    bit sig_level = 1'b0;
    bit s_hist [0:HIST-1];

    freq_meter_1hz_gate #(.GATE_CYCLES(GATE)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sig_in     (sig_in),
        .freq_out   (freq_out),
        .freq_valid (freq_valid),
        .overflow   (overflow)
    );

    freq_meter_1hz_gate #(.GATE_CYCLES(GATE), .CNT_WIDTH(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sig_in     (sig_in),
        .freq_out   (freq_out4),
        .freq_valid (freq_valid4),
        .overflow   (overflow4)
    );

    // ---------------- clock / history / stimulus source ----------------
    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < HIST) s_hist[cyc] = sig_in;
    end

    always @(negedge clk) begin
        if (sig_period < 0) begin
            sig_in = 1'($urandom_range(0, 1));
        end else if (sig_period == 0) begin
            sig_in = sig_level;
        end else begin
            ph = (ph + 1) % sig_period;
            sig_in = (ph < sig_period / 2);
        end
    end

    initial begin
        #(20 * 20000);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model and driver helpers ----------------
    // Rising edges of sig_in that the meter sees at clk edges a..b (3-cycle input delay).
    function automatic int rises(input int a, input int b);
        int n_r = 0;
        for (int n = a; n <= b; n++) begin
            if (n >= 3 && n < HIST && s_hist[n-2] && !s_hist[n-3]) n_r++;
        end
        return n_r;
    endfunction

    function automatic int sat_to(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Next terminal edge after now, for a measurement started at edge c0.
    function automatic int next_term();
        int t = c0 + FIRST_TERM;
        while (t <= cyc) t += GATE;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_period(input int p);
        sig_period = p;
        if (p > 0) ph = $urandom_range(0, p - 1);
    endtask

    task automatic wait_valid(input int limit, output int seen);
        seen = -1;
        for (int i = 0; i < limit && seen < 0; i++) begin
            tick();
            if (freq_valid === 1'b1) seen = cyc;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit bad_out = 1'b0;
        bit bad_state = 1'b0;
        set_period(10);
        reset = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (freq_out !== 27'd0 || freq_valid !== 1'b0 || overflow !== 1'b0 ||
                freq_out4 !== 4'd0 || freq_valid4 !== 1'b0) bad_out = 1'b1;
            if (dut.state !== ST_IDLE) bad_state = 1'b1;
        end
        checks++;
        if (bad_out) begin
            errors++;
            $display("FAIL reset_outputs: got out=%0d valid=%b ovf=%b, want 0/0/0", freq_out, freq_valid, overflow);
        end
        checks++;
        if (bad_state) begin
            errors++;
            $display("FAIL reset_wins_state: got %0d, want ST_IDLE while reset with en=1", dut.state);
        end
        reset = 1'b0;
        c0 = cyc + 1;
    endtask

    task automatic test_period();
        int exp_t, seen, n_r;
        for (int j = 0; j < 3; j++) begin
            exp_t = next_term();
            wait_valid(exp_t - cyc + 2, seen);
            n_r = rises(exp_t - GATE + 1, exp_t);
            checks++;
            if (seen !== exp_t || freq_valid4 !== 1'b1) begin
                errors++;
                $display("FAIL period_valid_time w%0d: got cycle %0d, want %0d", j, seen, exp_t);
            end
            checks++;
            if (freq_out !== 27'(n_r) || overflow !== 1'b0 || freq_out4 !== 4'(sat_to(n_r, 4))) begin
                errors++;
                $display("FAIL period_count w%0d: got %0d/%0d ovf=%b, want %0d/%0d ovf=0",
                         j, freq_out, freq_out4, overflow, n_r, sat_to(n_r, 4));
            end
            if (j >= 1) begin
                checks++;
                if (freq_out !== 27'd10 || overflow4 !== 1'b0) begin
                    errors++;
                    $display("FAIL period10_value w%0d: got %0d ovf4=%b, want 10 ovf4=0", j, freq_out, overflow4);
                end
            end
            tick();
            checks++;
            if (freq_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_pulse_width w%0d: got valid=%b one cycle later, want 0", j, freq_valid);
            end
        end
    endtask

    task automatic test_abort();
        int exp_t, seen, set_cyc;
        bit bad = 1'b0;
        exp_t = next_term();
        while (cyc < exp_t - 50) tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (freq_valid !== 1'b0 || freq_out !== 27'd10 || overflow !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_hold: got valid=%b out=%0d, want valid=0 out=10", freq_valid, freq_out);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_state: got %0d, want ST_IDLE", dut.state);
        end
        en = 1'b1;
        set_cyc = cyc;
        c0 = cyc + 1;
        wait_valid(FIRST_TERM + 5, seen);
        checks++;
        if (seen - set_cyc !== FLUSH_CYCLES + GATE + 1) begin
            errors++;
            $display("FAIL abort_restart_latency: got %0d cycles, want %0d", seen - set_cyc, FLUSH_CYCLES + GATE + 1);
        end
        checks++;
        if (freq_out !== 27'(rises(cyc - GATE + 1, cyc))) begin
            errors++;
            $display("FAIL abort_restart_count: got %0d, want %0d", freq_out, rises(cyc - GATE + 1, cyc));
        end
    endtask

    task automatic test_saturation();
        int exp_t, seen, n_r;
        set_period(4);
        for (int j = 0; j < 4; j++) begin
            if (j == 2) set_period(20);
            exp_t = next_term();
            wait_valid(exp_t - cyc + 2, seen);
            n_r = rises(exp_t - GATE + 1, exp_t);
            checks++;
            if (seen !== exp_t || freq_out !== 27'(n_r) || freq_out4 !== 4'(sat_to(n_r, 4)) ||
                overflow4 !== (n_r > 15)) begin
                errors++;
                $display("FAIL sat_model w%0d: got t=%0d %0d/%0d ovf4=%b, want t=%0d %0d/%0d ovf4=%b",
                         j, seen, freq_out, freq_out4, overflow4, exp_t, n_r, sat_to(n_r, 4), n_r > 15);
            end
            if (j == 1) begin
                checks++;
                if (freq_out4 !== 4'd15 || overflow4 !== 1'b1 || freq_out !== 27'd25 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_period4: got %0d ovf=%b (wide %0d), want 15 ovf=1 (wide 25)",
                             freq_out4, overflow4, freq_out);
                end
            end
            if (j == 3) begin
                checks++;
                if (freq_out4 !== 4'd5 || overflow4 !== 1'b0 || freq_out !== 27'd5) begin
                    errors++;
                    $display("FAIL sat_recover_period20: got %0d ovf=%b, want 5 ovf=0", freq_out4, overflow4);
                end
            end
        end
    endtask

    task automatic test_constant();
        int exp_t, seen;
        en = 1'b0;
        repeat (3) tick();
        sig_period = 0;
        sig_level = 1'b1;
        en = 1'b1;
        c0 = cyc + 1;
        for (int j = 0; j < 2; j++) begin
            exp_t = next_term();
            wait_valid(exp_t - cyc + 2, seen);
            checks++;
            if (seen !== exp_t || freq_out !== 27'd0 || overflow !== 1'b0 || freq_out4 !== 4'd0) begin
                errors++;
                $display("FAIL constant_high w%0d: got t=%0d out=%0d, want t=%0d out=0", j, seen, freq_out, exp_t);
            end
        end
    endtask

    task automatic test_terminal_edge();
        int exp_t, seen, n_r;
        sig_level = 1'b0;
        for (int j = 0; j < 4; j++) begin
            exp_t = next_term();
            if (j == 2) begin
                while (cyc < exp_t - 3) tick();
                sig_level = 1'b1;
            end
            wait_valid(exp_t - cyc + 2, seen);
            n_r = rises(exp_t - GATE + 1, exp_t);
            checks++;
            if (seen !== exp_t || freq_out !== 27'(n_r)) begin
                errors++;
                $display("FAIL terminal_model w%0d: got t=%0d out=%0d, want t=%0d out=%0d", j, seen, freq_out, exp_t, n_r);
            end
            if (j >= 2) begin
                checks++;
                if (freq_out !== ((j == 2) ? 27'd1 : 27'd0)) begin
                    errors++;
                    $display("FAIL terminal_edge w%0d: got %0d, want %0d", j, freq_out, (j == 2) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        int exp_t, seen, n_r;
        sig_period = -1;
        for (int j = 0; j < 3; j++) begin
            exp_t = next_term();
            wait_valid(exp_t - cyc + 2, seen);
            n_r = rises(exp_t - GATE + 1, exp_t);
            checks++;
            if (seen !== exp_t || freq_out !== 27'(n_r) || overflow !== 1'b0 ||
                freq_out4 !== 4'(sat_to(n_r, 4)) || overflow4 !== (n_r > 15)) begin
                errors++;
                $display("FAIL random_window w%0d: got t=%0d %0d/%0d ovf4=%b, want t=%0d %0d/%0d ovf4=%b",
                         j, seen, freq_out, freq_out4, overflow4, exp_t, n_r, sat_to(n_r, 4), n_r > 15);
            end
        end
    endtask

    task automatic test_reset_mid();
        int exp_t, seen, n_r;
        repeat (40) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (freq_out !== 27'd0 || overflow !== 1'b0 || freq_valid !== 1'b0 ||
            freq_out4 !== 4'd0 || overflow4 !== 1'b0 || dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid: got out=%0d ovf=%b valid=%b state=%0d, want 0/0/0/ST_IDLE",
                     freq_out, overflow, freq_valid, dut.state);
        end
        reset = 1'b0;
        c0 = cyc + 1;
        tick();
        checks++;
        if (dut.state !== ST_FLUSH) begin
            errors++;
            $display("FAIL reset_mid_flush: got state %0d, want ST_FLUSH", dut.state);
        end
        exp_t = next_term();
        wait_valid(exp_t - cyc + 2, seen);
        n_r = rises(exp_t - GATE + 1, exp_t);
        checks++;
        if (seen !== exp_t || freq_out !== 27'(n_r) || freq_out4 !== 4'(sat_to(n_r, 4))) begin
            errors++;
            $display("FAIL reset_mid_restart: got t=%0d out=%0d, want t=%0d out=%0d", seen, freq_out, exp_t, n_r);
        end
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        test_reset();
        test_period();
        test_abort();
        test_saturation();
        test_constant();
        test_terminal_edge();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
